user_io_master: RTL and testbench

USER_IO_MASTER -- requirements
Module: user_io_master

---
 rtl/user_io_master_pkg.sv | 30 +++
 rtl/user_io_master_spi_clk_gen.sv | 62 ++++++
 rtl/user_io_master.sv | 157 +++++++++++++++
 tb/tb_user_io_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_io_master_pkg.sv
// ----------------------------------------------------------------------------
// user_io_master_pkg
// Shared definitions for the user_io SPI link: the master FSM state encoding,
// the command bytes understood by the user_io slave, and the payload-length
// clamp used when a frame request is accepted.
// ----------------------------------------------------------------------------
package user_io_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Command bytes decoded by the user_io slave.
    localparam logic [7:0] CMD_JOY0    = 8'h01;
    localparam logic [7:0] CMD_JOY1    = 8'h02;
    localparam logic [7:0] CMD_MOUSE   = 8'h04;
    localparam logic [7:0] CMD_BUTTONS = 8'h08;

    // PAYLOAD carries at most four bytes.
    localparam logic [2:0] MAX_PAYLOAD_BYTES = 3'd4;

    function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
        return (n > MAX_PAYLOAD_BYTES) ? MAX_PAYLOAD_BYTES : n;
    endfunction

endpackage

// File: rtl/user_io_master_spi_clk_gen.sv
// ----------------------------------------------------------------------------
// spi_clk_gen
// Half-period timer for the SPI master. While run is high it counts CLK_DIV
// CLKCPU_A cycles per half period and pulses tick at the end of each one.
// While shift_en is also high each tick toggles the serial clock and is
// reported as a rise or fall strobe (strobes describe the edge being made on
// this cycle's clock edge).
//
// Ports:
//   CLKCPU_A  in   system clock
//   RESET     in   asynchronous active-high reset
//   run       in   timer enable; counter held at 0 when low
//   shift_en  in   allow ticks to toggle the serial clock
//   tick      out  end of a half period
//   rise      out  this tick drives sck 0->1
//   fall      out  this tick drives sck 1->0
//   sck       out  serial clock level (flop)
// ----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic CLKCPU_A,
    input  logic RESET,
    input  logic run,
    input  logic shift_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sck
);
    import user_io_master_pkg::*;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic [7:0] half_cnt_reg;
    logic       sck_reg;

    assign tick = run && (half_cnt_reg == HALF_LAST);
    assign rise = tick && shift_en && !sck_reg;
    assign fall = tick && shift_en && sck_reg;
    assign sck  = sck_reg;

    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            half_cnt_reg <= 8'd0;
            sck_reg      <= 1'b0;
        end else begin
            if (!run || tick) begin
                half_cnt_reg <= 8'd0;
            end else begin
                half_cnt_reg <= half_cnt_reg + 8'd1;
            end

            if (!run) begin
                sck_reg <= 1'b0;
            end else if (tick && shift_en) begin
                sck_reg <= !sck_reg;
            end
        end
    end

endmodule

// File: rtl/user_io_master.sv
// ----------------------------------------------------------------------------
// user_io_master
// SPI mode-0 master sending one command byte plus 0..4 payload bytes, MSB
// first. The MISO byte returned during the command byte is kept as CORE_ID.
//
// Ports:
//   CLKCPU_A  in   system clock
//   RESET     in   asynchronous active-high reset
//   START     in   single-cycle frame request (ignored while BUSY)
//   CMD       in   command byte
//   PAYLOAD   in   payload, byte 0 = PAYLOAD[31:24]
//   NBYTES    in   payload byte count (5..7 treated as 4)
//   BUSY      out  frame in progress
//   DONE      out  one-cycle end-of-frame pulse
//   CORE_ID   out  byte received during the command byte
//   SPI_NSS   out  active-low slave select
//   SPI_CK    out  serial clock, idles low
//   SPI_MOSI  out  serial data out
//   SPI_MISO  in   serial data in
// ----------------------------------------------------------------------------
module user_io_master #(
    parameter int CLK_DIV  = 4,
    parameter int HOLD_CYC = 4
) (
    input  logic        CLKCPU_A,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  CMD,
    input  logic [31:0] PAYLOAD,
    input  logic [2:0]  NBYTES,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  CORE_ID,
    output logic        SPI_NSS,
    output logic        SPI_CK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);
    import user_io_master_pkg::*;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t      state_reg, state_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        nss_reg, nss_next;

    logic [7:0]  sh_reg;        // MOSI shift register, bit 7 is on the wire
    logic [31:0] pay_reg;       // remaining payload, next byte in [31:24]
    logic [2:0]  nbytes_reg;
    logic [2:0]  bit_cnt_reg;   // bits completed in the current byte
    logic [2:0]  byte_cnt_reg;  // 0 = command byte
    logic [6:0]  rx_reg;
    logic [7:0]  core_id_reg;
    logic [7:0]  hold_cnt_reg;

    logic        tick, rise, fall, sck;
    logic        last_fall;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .CLKCPU_A (CLKCPU_A),
        .RESET    (RESET),
        .run      ((state_reg == SETUP) || (state_reg == SHIFT)),
        .shift_en (state_reg == SHIFT),
        .tick     (tick),
        .rise     (rise),
        .fall     (fall),
        .sck      (sck)
    );

    assign last_fall = fall && (bit_cnt_reg == 3'd7) && (byte_cnt_reg == nbytes_reg);

    // Outputs are registered copies of the next-state decode so that every
    // pin comes straight from a flop.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (START)                        state_next = SETUP;
            SETUP:   if (tick)                         state_next = SHIFT;
            SHIFT:   if (last_fall)                    state_next = HOLD;
            HOLD:    if (hold_cnt_reg == HOLD_LAST)    state_next = FIN;
            FIN:                                       state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == FIN);
        nss_next  = !((state_next == SETUP) || (state_next == SHIFT));
    end

    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            nss_reg      <= 1'b1;
            sh_reg       <= 8'h00;
            pay_reg      <= 32'h0;
            nbytes_reg   <= 3'd0;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 3'd0;
            rx_reg       <= 7'h00;
            core_id_reg  <= 8'h00;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            nss_reg   <= nss_next;

            if ((state_reg == IDLE) && START) begin
                sh_reg       <= CMD;
                pay_reg      <= PAYLOAD;
                nbytes_reg   <= clamp_nbytes(NBYTES);
                bit_cnt_reg  <= 3'd0;
                byte_cnt_reg <= 3'd0;
            end else if (state_reg == SHIFT) begin
                // Only the command byte's MISO bits are kept.
                if (rise && (byte_cnt_reg == 3'd0)) begin
                    rx_reg <= {rx_reg[5:0], SPI_MISO};
                    if (bit_cnt_reg == 3'd7) begin
                        core_id_reg <= {rx_reg, SPI_MISO};
                    end
                end
                if (fall) begin
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_reg <= 3'd0;
                        if (byte_cnt_reg == nbytes_reg) begin
                            // Frame over: park MOSI low for HOLD/IDLE.
                            sh_reg       <= 8'h00;
                            byte_cnt_reg <= 3'd0;
                        end else begin
                            // Next byte goes on the wire on this same edge.
                            byte_cnt_reg <= byte_cnt_reg + 3'd1;
                            sh_reg       <= pay_reg[31:24];
                            pay_reg      <= {pay_reg[23:0], 8'h00};
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        sh_reg      <= {sh_reg[6:0], 1'b0};
                    end
                end
            end

            hold_cnt_reg <= (state_reg == HOLD) ? hold_cnt_reg + 8'd1 : 8'd0;
        end
    end

    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign CORE_ID  = core_id_reg;
    assign SPI_NSS  = nss_reg;
    assign SPI_CK   = sck;
    assign SPI_MOSI = sh_reg[7];

endmodule

// File: tb/tb_user_io_master.sv
`timescale 1ns/1ps
module tb_user_io_master;
    import user_io_master_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int HOLD_CYC = 8;
    localparam int ABORT_CYC = CLK_DIV + 16 * CLK_DIV + 2 * CLK_DIV;

    logic        CLKCPU_A = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  CMD;
    logic [31:0] PAYLOAD;
    logic [2:0]  NBYTES;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  CORE_ID;
    logic        SPI_NSS;
    logic        SPI_CK;
    logic        SPI_MOSI;
    logic        SPI_MISO;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    logic [7:0] frame_q[$];

    // SPI slave model state
    logic [7:0]  slave_resp = 8'h00;
    int          miso_bits  = 0;
    logic        rnd_bit    = 1'b0;
    logic [7:0]  mon_sh     = 8'h00;
    int          mon_bits   = 0;
    logic [7:0]  mouse_buttons = 8'h00;
    logic [15:0] mouse_data    = 16'h0000;

    // per-frame observations
    int   f_cyc, f_pulses, f_nss_low, f_done;
    logic f_busy_first, f_busy_at_done, f_aborted;

    user_io_master #(
        .CLK_DIV  (CLK_DIV),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .CLKCPU_A (CLKCPU_A),
        .RESET    (RESET),
        .START    (START),
        .CMD      (CMD),
        .PAYLOAD  (PAYLOAD),
        .NBYTES   (NBYTES),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CORE_ID  (CORE_ID),
        .SPI_NSS  (SPI_NSS),
        .SPI_CK   (SPI_CK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO)
    );

    always #5 CLKCPU_A = ~CLKCPU_A;

    // Mode-0 slave transmitter: response byte MSB first, random filler after.
    assign SPI_MISO = (miso_bits < 8) ? slave_resp[3'(7 - miso_bits)] : rnd_bit;

    always @(negedge SPI_CK or posedge SPI_NSS) begin
        if (SPI_NSS) begin
            miso_bits = 0;
        end else begin
            miso_bits = miso_bits + 1;
            rnd_bit   = 1'($urandom);
        end
    end

    // Slave receiver: MOSI sampled on rising SPI_CK.
    always @(posedge SPI_CK or negedge SPI_NSS) begin
        if (!SPI_CK) begin
            mon_bits = 0;
            frame_q.delete();
        end else if (!SPI_NSS) begin
            mon_sh   = {mon_sh[6:0], SPI_MOSI};
            mon_bits = mon_bits + 1;
            if (mon_bits == 8) begin
                mon_bits = 0;
                act_q.push_back(mon_sh);
                frame_q.push_back(mon_sh);
            end
        end
    end

    // user_io slave decode of a mouse frame.
    always @(posedge SPI_NSS) begin
        if (frame_q.size() == 4 && frame_q[0] == CMD_MOUSE) begin
            mouse_buttons = frame_q[1];
            mouse_data    = {frame_q[2], frame_q[3]};
        end
    end

    function automatic int frame_len(input int n);
        return CLK_DIV + 2 * CLK_DIV * 8 * (1 + n) + HOLD_CYC + 1;
    endfunction

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] payload,
                             input logic [2:0] nb, input logic [7:0] resp,
                             input bit restart, input bit abort_mid);
        int          n_exp;
        logic        ck_prev;
        logic [31:0] p;
        n_exp = (nb > 3'd4) ? 4 : int'(nb);
        exp_q.push_back(cmd);
        p = payload;
        for (int i = 0; i < n_exp; i++) begin
            exp_q.push_back(p[31:24]);
            p = p << 8;
        end
        slave_resp = resp;
        f_cyc = 0; f_pulses = 0; f_nss_low = 0; f_done = 0;
        f_aborted = 1'b0; f_busy_first = 1'b0; f_busy_at_done = 1'b0; ck_prev = 1'b0;
        @(negedge CLKCPU_A);
        CMD = cmd; PAYLOAD = payload; NBYTES = nb; START = 1'b1;
        while (f_done == 0 && !f_aborted && f_cyc < 4000) begin
            @(negedge CLKCPU_A);
            f_cyc++;
            if (f_cyc == 1) begin
                START = 1'b0;
                f_busy_first = BUSY;
                CMD = ~cmd; PAYLOAD = ~payload; NBYTES = nb + 3'd1;
            end
            if (restart && f_cyc == 10) begin START = 1'b1; CMD = 8'hFF; end
            if (restart && f_cyc == 11) START = 1'b0;
            if (SPI_CK && !ck_prev) f_pulses++;
            ck_prev = SPI_CK;
            if (!SPI_NSS) f_nss_low++;
            if (DONE) begin f_done++; f_busy_at_done = BUSY; end
            if (abort_mid && f_cyc >= ABORT_CYC && SPI_CK) f_aborted = 1'b1;
        end
        if (f_done == 0 && !f_aborted) begin
            n_checks++;
            $display("FAIL frame_timeout: no DONE after %0d cycles, required DONE", f_cyc);
        end
        $display("frame cmd=%02h nbytes=%0d cycles=%0d pulses=%0d nss_low=%0d core_id=%02h",
                 cmd, nb, f_cyc, f_pulses, f_nss_low, CORE_ID);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLKCPU_A);
        n_checks++; if (SPI_NSS !== 1'b1) $display("FAIL reset_nss: got %b, required 1", SPI_NSS); else n_pass++;
        n_checks++; if (SPI_CK !== 1'b0) $display("FAIL reset_ck: got %b, required 0", SPI_CK); else n_pass++;
        n_checks++; if (SPI_MOSI !== 1'b0) $display("FAIL reset_mosi: got %b, required 0", SPI_MOSI); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b, required 0", BUSY); else n_pass++;
        n_checks++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b, required 0", DONE); else n_pass++;
        n_checks++; if (CORE_ID !== 8'h00) $display("FAIL reset_core_id: got %02h, required 00", CORE_ID); else n_pass++;
        RESET = 1'b0;
        @(negedge CLKCPU_A);
    endtask

    task automatic test_basic();
        logic [7:0] e, a;
        run_frame(CMD_JOY0, 32'hA5_00_00_00, 3'd1, 8'hA1, 1'b0, 1'b0);
        n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d bytes, required %0d", act_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL basic_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("basic byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (CORE_ID !== 8'hA1) $display("FAIL basic_core_id: got %02h, required a1", CORE_ID); else n_pass++;
        n_checks++; if (f_cyc != 141) $display("FAIL basic_len: got %0d, required 141", f_cyc); else n_pass++;
        n_checks++; if (f_pulses != 16) $display("FAIL basic_pulses: got %0d, required 16", f_pulses); else n_pass++;
        n_checks++; if (f_busy_first !== 1'b1) $display("FAIL basic_busy_start: got %b, required 1", f_busy_first); else n_pass++;
        n_checks++; if (f_busy_at_done !== 1'b1) $display("FAIL basic_busy_fin: got %b, required 1", f_busy_at_done); else n_pass++;
        @(negedge CLKCPU_A);
        n_checks++; if (DONE !== 1'b0) $display("FAIL basic_done_width: got %b, required 0", DONE); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL basic_busy_end: got %b, required 0", BUSY); else n_pass++;
    endtask

    task automatic test_cmd_only();
        logic [7:0] e, a;
        run_frame(CMD_BUTTONS, 32'hDEAD_BEEF, 3'd0, 8'h5A, 1'b0, 1'b0);
        n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL cmdonly_count: got %0d bytes, required %0d", act_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL cmdonly_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("cmdonly byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (f_pulses != 8) $display("FAIL cmdonly_pulses: got %0d, required 8", f_pulses); else n_pass++;
        n_checks++; if (f_nss_low != 68) $display("FAIL cmdonly_nss_low: got %0d, required 68", f_nss_low); else n_pass++;
        n_checks++; if (f_cyc != frame_len(0)) $display("FAIL cmdonly_len: got %0d, required %0d", f_cyc, frame_len(0)); else n_pass++;
        n_checks++; if (CORE_ID !== 8'h5A) $display("FAIL cmdonly_core_id: got %02h, required 5a", CORE_ID); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [7:0] e, a;
        run_frame(CMD_JOY1, 32'h11223344, 3'd7, 8'hC6, 1'b0, 1'b0);
        n_checks++; if (act_q.size() != 5) $display("FAIL clamp_count: got %0d bytes, required 5", act_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL clamp_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("clamp byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (f_pulses != 40) $display("FAIL clamp_pulses: got %0d, required 40", f_pulses); else n_pass++;
        n_checks++; if (f_cyc != frame_len(4)) $display("FAIL clamp_len: got %0d, required %0d", f_cyc, frame_len(4)); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        logic [7:0] e, a;
        int extra_done;
        run_frame(CMD_JOY1, 32'h3C_96_00_00, 3'd2, 8'h42, 1'b1, 1'b0);
        n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL restart_count: got %0d bytes, required %0d", act_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL restart_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("restart byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (f_cyc != frame_len(2)) $display("FAIL restart_len: got %0d, required %0d", f_cyc, frame_len(2)); else n_pass++;
        extra_done = 0;
        repeat (30) begin
            @(negedge CLKCPU_A);
            if (DONE !== 1'b0) extra_done++;
        end
        n_checks++; if (extra_done != 0) $display("FAIL restart_extra_done: got %0d, required 0", extra_done); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL restart_busy: got %b, required 0", BUSY); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, a;
        int done_cnt;
        run_frame(CMD_JOY0, 32'hC3_5A_00_00, 3'd2, 8'h3C, 1'b0, 1'b1);
        n_checks++; if (f_aborted !== 1'b1) $display("FAIL rstmid_reach: got %b, required 1", f_aborted); else n_pass++;
        n_checks++; if (CORE_ID !== 8'h3C) $display("FAIL rstmid_core_pre: got %02h, required 3c", CORE_ID); else n_pass++;
        RESET = 1'b1;
        #1;
        n_checks++; if (SPI_NSS !== 1'b1) $display("FAIL rstmid_nss: got %b, required 1", SPI_NSS); else n_pass++;
        n_checks++; if (SPI_CK !== 1'b0) $display("FAIL rstmid_ck: got %b, required 0", SPI_CK); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", BUSY); else n_pass++;
        n_checks++; if (CORE_ID !== 8'h00) $display("FAIL rstmid_core_id: got %02h, required 00", CORE_ID); else n_pass++;
        done_cnt = 0;
        repeat (4) begin
            @(negedge CLKCPU_A);
            if (DONE !== 1'b0) done_cnt++;
        end
        RESET = 1'b0;
        repeat (3) begin
            @(negedge CLKCPU_A);
            if (DONE !== 1'b0) done_cnt++;
        end
        n_checks++; if (done_cnt != 0) $display("FAIL rstmid_done: got %0d pulses, required 0", done_cnt); else n_pass++;
        exp_q.delete(); act_q.delete();
        run_frame(CMD_JOY1, 32'h7E_81_00_00, 3'd2, 8'h99, 1'b0, 1'b0);
        n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d bytes, required %0d", act_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL rstmid_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("rstmid byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (CORE_ID !== 8'h99) $display("FAIL rstmid_core_post: got %02h, required 99", CORE_ID); else n_pass++;
        n_checks++; if (f_cyc != frame_len(2)) $display("FAIL rstmid_len: got %0d, required %0d", f_cyc, frame_len(2)); else n_pass++;
    endtask

    task automatic test_mouse();
        logic [7:0] e, a;
        run_frame(CMD_MOUSE, 32'h01_05_FB_00, 3'd3, 8'hE7, 1'b0, 1'b0);
        n_checks++; if (act_q.size() != exp_q.size()) $display("FAIL mouse_count: got %0d bytes, required %0d", act_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) $display("FAIL mouse_byte: got %02h, required %02h", a, e);
            else begin n_pass++; $display("mouse byte %02h ok", a); end
        end
        exp_q.delete(); act_q.delete();
        n_checks++; if (mouse_buttons !== 8'h01) $display("FAIL mouse_buttons: got %02h, required 01", mouse_buttons); else n_pass++;
        n_checks++; if (mouse_data !== 16'h05FB) $display("FAIL mouse_data: got %04h, required 05fb", mouse_data); else n_pass++;
        n_checks++; if (CORE_ID !== 8'hE7) $display("FAIL mouse_core_id: got %02h, required e7", CORE_ID); else n_pass++;
    endtask

    initial begin
        RESET   = 1'b1;
        START   = 1'b0;
        CMD     = 8'h00;
        PAYLOAD = 32'h0;
        NBYTES  = 3'd0;
        test_reset();
        test_basic();
        test_cmd_only();
        test_clamp();
        test_restart_ignored();
        test_reset_mid();
        test_mouse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
